// File: rtl/led_share_arb_if.sv
// Bundle between the LED pattern sources and the LED bank arbiter.
// Sources drive requests and patterns; the arbiter drives grant, LED value and slot-end pulse.
interface led_share_arb_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] pat;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         led;
    logic               slot_end;

    modport master (
        output req,
        output pat,
        input  grant,
        input  led,
        input  slot_end
    );

    modport slave (
        input  req,
        input  pat,
        output grant,
        output led,
        output slot_end
    );
endinterface

// File: rtl/led_share_arb.sv
// Round-robin time-sharing of the 8-LED bank between N_REQ pattern sources,
// with a minimum dwell per owner and an optional blank gap between owners.
//
// state  | meaning
// S_IDLE | nobody owns the bank, LEDs show IDLE_PAT
// S_OWN  | owner's pattern drives the LEDs, cnt counts slot cycles
// S_GAP  | blank LEDs between two owners, cnt counts gap cycles
module led_share_arb #(
    parameter int         N_REQ    = 4,
    parameter int         DWELL    = 12_500_000,
    parameter int         GAP      = 1_250_000,
    parameter logic [7:0] IDLE_PAT = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    led_share_arb_if.slave bus
);
    localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   last, last_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   win;
    logic               win_vld;
    logic [N_REQ-1:0]   grant_nxt;
    logic [N_REQ-1:0]   others;
    logic [7:0]         led_nxt;
    logic               slot_end_nxt;
    logic               end_slot;
    logic               dwell_done;
    logic               gap_done;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    function automatic logic [7:0] pat_of(input logic [IDX_W-1:0] i);
        pat_of = bus.pat[8*int'(i) +: 8];
    endfunction

    // Rotating search: index last+1 has top priority, last itself lowest.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_vld && bus.req[(int'(last) + k) % N_REQ]) begin
                win_vld = 1'b1;
                win     = IDX_W'((int'(last) + k) % N_REQ);
            end
        end
    end

    assign dwell_done = (int'(cnt) == DWELL - 1);
    assign gap_done   = (int'(cnt) == GAP - 1);
    assign others     = bus.req & ~onehot(owner);

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_nxt     = last;
        cnt_nxt      = cnt;
        grant_nxt    = '0;
        led_nxt      = IDLE_PAT;
        slot_end_nxt = 1'b0;
        end_slot     = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    state_nxt = S_OWN;
                    owner_nxt = win;
                    last_nxt  = win;
                    cnt_nxt   = '0;
                    grant_nxt = onehot(win);
                    led_nxt   = pat_of(win);
                end
            end
            S_OWN: begin
                grant_nxt = onehot(owner);
                led_nxt   = pat_of(owner);
                cnt_nxt   = cnt + CNT_W'(1);
                // Owner release beats dwell expiry; both give a single slot end.
                if (!bus.req[owner]) begin
                    end_slot = 1'b1;
                end else if (dwell_done) begin
                    if (|others) end_slot = 1'b1;
                    else         cnt_nxt  = '0;
                end
                if (end_slot) begin
                    slot_end_nxt = 1'b1;
                    grant_nxt    = '0;
                    cnt_nxt      = '0;
                    if (GAP > 0) begin
                        state_nxt = S_GAP;
                        led_nxt   = 8'h00;
                    end else if (win_vld) begin
                        owner_nxt = win;
                        last_nxt  = win;
                        grant_nxt = onehot(win);
                        led_nxt   = pat_of(win);
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                led_nxt = 8'h00;
                cnt_nxt = cnt + CNT_W'(1);
                if (gap_done) begin
                    cnt_nxt = '0;
                    if (win_vld) begin
                        state_nxt = S_OWN;
                        owner_nxt = win;
                        last_nxt  = win;
                        grant_nxt = onehot(win);
                        led_nxt   = pat_of(win);
                    end else begin
                        state_nxt = S_IDLE;
                        led_nxt   = IDLE_PAT;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            owner        <= '0;
            last         <= IDX_W'(N_REQ - 1);
            cnt          <= '0;
            bus.grant    <= '0;
            bus.led      <= IDLE_PAT;
            bus.slot_end <= 1'b0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            last         <= last_nxt;
            cnt          <= cnt_nxt;
            bus.grant    <= grant_nxt;
            bus.led      <= led_nxt;
            bus.slot_end <= slot_end_nxt;
        end
    end
endmodule

// File: doc/led_share_arb.md
# led_share_arb

Time-shares the board's 8-LED bank between several pattern sources, for example a free-running blink counter, a status display and a debug probe. Each requester drives an 8-bit pattern and raises a request. The block grants the LEDs round-robin, holds each owner for a minimum dwell time, and inserts a short blank gap between owners. It sits between the pattern generators and the top-level `led_o` pins, clocked by the board clock.

## Interface
- `N_REQ`, default 4: number of requesters, valid range 2..8.
- `DWELL`, default 12_500_000: slot length in clock cycles, ≥ 2.
- `GAP`, default 1_250_000: blank cycles between two owners; 0 means no gap.
- `IDLE_PAT`, default 8'h00: LED value shown when nobody owns the bank.
- `clk_i`  in  1: board clock, single clock domain.
- `rst_i`  in  1: reset, synchronous, active-high.
- `req_i`  in  N_REQ: level request per source; bit i belongs to source i.
- `pat_i`  in  8*N_REQ: LED patterns; source i occupies bits [8i+7:8i].
- `grant_o`  out  N_REQ: one-hot current owner, or all zero.
- `led_o`  out  8: registered LED drive.
- `slot_end_o`  out  1: one-cycle pulse on the edge where ownership ends.

## Operation
States are IDLE, OWN and GAP. Registered state:
- `owner` index.
- `last` index: the previous owner, which sets round-robin priority.
- `cnt` counter, width `$clog2(max(DWELL,GAP))`, never less than 1.

Arbitration:
- Search starts at index `last+1` and wraps modulo `N_REQ`.
- The first set `req_i` bit wins.
- The arbitration result is valid only in IDLE and at the final GAP cycle.

IDLE:
- Outputs: `grant_o=0`, `led_o=IDLE_PAT`.
- If any `req_i` is set: go to OWN with the winner, set `cnt=0`, `last=winner`.

OWN:
- Outputs: `grant_o` is one-hot on the owner; `led_o <= pat_i[owner]` every cycle.
- `cnt` increments each cycle.
- The owner's `req_i` dropping takes priority: end the slot immediately.
- Otherwise, when `cnt==DWELL-1`:
  - If any other `req_i` is set, end the slot.
  - Otherwise the owner keeps the bank (renewal): `cnt` wraps to 0 and `slot_end_o` stays 0.
- Ending a slot:
  - `slot_end_o=1` for that edge.
  - `grant_o` clears on the same edge.
  - If `GAP>0`, go to GAP with `cnt=0`.
  - If `GAP==0`, arbitrate immediately, excluding nobody; the same owner may win again only if it is the sole requester.

GAP:
- Outputs: `grant_o=0`, `led_o=8'h00`.
- Lasts `GAP` cycles.
- At `cnt==GAP-1`: if any request is set, go to OWN with the winner; otherwise go to IDLE.
- Requests that drop during GAP are simply not seen.

Invariants:
- `grant_o` is always zero or one-hot; never two bits set.
- `pat_i` of non-owners has no effect on `led_o`.

## Timing
- Reset values, visible after the first edge with `rst_i=1`:
  - state = IDLE, `last = N_REQ-1` (source 0 has first priority)
  - `cnt = 0`, `grant_o = 0`, `led_o = IDLE_PAT`, `slot_end_o = 0`
- `rst_i` asserted mid-slot or mid-gap takes effect on that edge and overrides every other transition.
- Grant latency: a request sampled at edge k in IDLE gives `grant_o` and `led_o=pat_i[owner]` valid after edge k, i.e. 1 cycle.
- `led_o` follows a change on the owner's `pat_i` with 1 cycle of latency.
- Slot length: exactly `DWELL` cycles of `grant_o` when contended, counted from the grant edge to the `slot_end_o` edge inclusive.
- Early release: `req_i[owner]` low at edge k gives `grant_o=0` and `slot_end_o=1` after edge k.
- Gap length: exactly `GAP` cycles with `grant_o=0` between two owners.
- Simultaneous events:
  - Dwell expiry and owner release on the same edge count as a single slot end with one `slot_end_o` pulse.
  - A request arriving on the final GAP edge is included in arbitration.

## Test plan
All scenarios use `N_REQ=4`, `DWELL=4`, `GAP=2`, `IDLE_PAT=8'hA5`, and `pat_i` = {8'h44, 8'h33, 8'h22, 8'h11}.
- **Reset and idle.** Hold `rst_i` for 2 cycles with `req_i=0`, then release. Required: `grant_o=0`, `led_o=8'hA5` and `slot_end_o=0` for 10 cycles.
- **Single requester renewal.** Set `req_i=4'b0100` permanently. Required: `grant_o=4'b0100` after 1 cycle, `led_o=8'h33` thereafter, no `slot_end_o` and no gap for 20 cycles.
- **Round-robin under contention.** Set `req_i=4'b1111` from reset. Required:
  - Grant order is 0, 1, 2, 3, 0.
  - Each grant lasts exactly 4 cycles, followed by 2 cycles of `led_o=8'h00`.
  - `slot_end_o` pulses once per slot.
- **Early release.** Owner 1 drops `req_i[1]` at slot cycle 1 while `req_i[3]` is set. Required: `slot_end_o` pulses at that edge, 2 gap cycles follow, then `grant_o=4'b1000` and `led_o=8'h44`.
- **Reset mid-slot.** Pulse `rst_i` at slot cycle 2 while `req_i=4'b0110`. Required: outputs return to reset values on that edge, and the next grant goes to source 1 (priority restarts at 0).
- **Pattern tracking and isolation.** During owner 0's slot, change `pat_i[7:0]` to 8'hF0 and `pat_i[15:8]` to 8'h0F. Required: `led_o=8'hF0` one cycle later, with no effect from source 1.
